// File: rtl/input_cond_pkg.sv
// Shared types and default parameter values for the input conditioner.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } debounce_state_t;

    localparam int DEF_CHANNELS        = 2;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_CYCLES   = 1024;

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: synchroniser, debounce FSM with down-counter and,
// when AUTO_REPEAT_EN is defined, an auto-repeat counter active in HIGH.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic n_reset,
    input  logic raw_in,
    output logic level_out,
    output logic pulse_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    debounce_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   press_s;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign level_out = level_q;
    assign pulse_out = pulse_q;

    // Synchroniser shift chain for the asynchronous raw input.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Debounce next-state logic; the counter only moves while a WAIT state is pending.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_s = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync_s) begin
                    state_d = RISE_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            RISE_WAIT: begin
                if (!sync_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = HIGH;
                    press_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync_s) begin
                    state_d = FALL_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = HIGH;
                end
            end
            FALL_WAIT: begin
                if (sync_s) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        level_d = (state_d == HIGH) || (state_d == FALL_WAIT);
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_fire_s;

    // Repeat counter runs while HIGH persists, holds through FALL_WAIT, clears otherwise.
    always_comb begin
        rep_d      = rep_q;
        rep_fire_s = 1'b0;
        if (state_q == HIGH && state_d == HIGH) begin
            if (rep_q == REP_LAST) begin
                rep_d      = REP_ZERO;
                rep_fire_s = 1'b1;
            end else begin
                rep_d = rep_q + REP_ONE;
            end
        end else if (state_d == IDLE || state_d == RISE_WAIT) begin
            rep_d = REP_ZERO;
        end else begin
            rep_d = rep_q;
        end
        pulse_d = press_s | rep_fire_s;
    end

    // Repeat counter register.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            rep_q <= REP_ZERO;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign pulse_d = press_s;
`endif

    // FSM, counter and registered outputs.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Top level: CHANNELS independent debounce channels. Define AUTO_REPEAT_EN
// to enable held-button auto-repeat pulses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                clock,
    input  logic                n_reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clock     (clock),
            .n_reset   (n_reset),
            .raw_in    (raw_in[g]),
            .level_out (level_out[g]),
            .pulse_out (pulse_out[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// toggling, compared against a run-length reference model every cycle.
module tb_input_conditioner;

    localparam int CH  = 2;
    localparam int SYN = 2;
    localparam int DEB = 4;
    localparam int REP = 8;

    logic          clock;
    logic          n_reset;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] level_out;
    logic [CH-1:0] pulse_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [CH-1:0] dq[$];
    logic [CH-1:0] exp_level;
    logic [CH-1:0] exp_pulse;
    int            run_len[CH];
    int            rep_cnt[CH];

    input_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SYN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .raw_in    (raw_in),
        .level_out (level_out),
        .pulse_out (pulse_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < SYN; i++) dq.push_back('0);
        exp_level = '0;
        exp_pulse = '0;
        for (int c = 0; c < CH; c++) begin
            run_len[c] = 0;
            rep_cnt[c] = 0;
        end
    endtask

    // A level change is accepted once DEB+1 consecutive synchronised samples disagree with it.
    task automatic model_step();
        logic [CH-1:0] seen;
        bit            was_high;
        seen = dq.pop_front();
        dq.push_back(raw_in);
        for (int c = 0; c < CH; c++) begin
            exp_pulse[c] = 1'b0;
            was_high = exp_level[c] && (run_len[c] == 0);
            if (seen[c] != exp_level[c]) run_len[c]++;
            else run_len[c] = 0;
            if (run_len[c] == DEB + 1) begin
                exp_level[c] = ~exp_level[c];
                run_len[c]   = 0;
                if (exp_level[c]) exp_pulse[c] = 1'b1;
            end
`ifdef AUTO_REPEAT_EN
            if (was_high && exp_level[c] && run_len[c] == 0) begin
                rep_cnt[c]++;
                if (rep_cnt[c] == REP) begin
                    exp_pulse[c] = 1'b1;
                    rep_cnt[c]   = 0;
                end
            end else if (!exp_level[c]) begin
                rep_cnt[c] = 0;
            end
`else
            if (was_high) rep_cnt[c] = 0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (n_reset) model_step();
        @(negedge clock);
        chk("level", level_out, exp_level);
        chk("pulse", pulse_out, exp_pulse);
    endtask

    initial begin
        int first;
        int npulse;
        int hold[CH];
        bit seen_any;
        logic [0:11] bounce;
        logic [CH-1:0] want;

        n_reset = 1'b0;
        raw_in  = '0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("por_level", level_out, 2'b00);
        n_reset = 1'b1;

        // 1: reset asserted mid-cycle with both inputs high
        raw_in = 2'b11;
        repeat (10) tick();
        chk("pre_reset_level", level_out, 2'b11);
        #3;
        n_reset = 1'b0;
        model_reset();
        #1;
        chk("rst_level_now", level_out, 2'b00);
        chk("rst_pulse_now", pulse_out, 2'b00);
        repeat (3) begin
            @(negedge clock);
            chk("rst_level_hold", level_out, 2'b00);
            chk("rst_pulse_hold", pulse_out, 2'b00);
        end
        // raw high across reset release: full press sequence, one pulse
        n_reset = 1'b1;
        npulse = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (pulse_out[0]) npulse++;
            if (e == 6) chk("release_press_e6", pulse_out, 2'b11);
        end
        chk("release_one_pulse", 2'(npulse), 2'd1);
        raw_in = 2'b00;
        repeat (10) tick();

        // 2: clean press on channel 0
        raw_in = 2'b01;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (e == 5) chk("press_e5_level", level_out, 2'b00);
            if (e == 6) begin
                chk("press_e6_level", level_out, 2'b01);
                chk("press_e6_pulse", pulse_out, 2'b01);
            end
            if (e == 7) chk("press_e7_pulse", pulse_out, 2'b00);
        end

        // 4: release from HIGH, no pulse
        raw_in = 2'b00;
        first = -1;
        npulse = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (pulse_out[0]) npulse++;
            if (!level_out[0] && first < 0) first = e;
        end
        chk("release_edge", 4'(first), 4'd6);
        chk("release_no_pulse", 2'(npulse), 2'd0);

        // 3: bounce on channel 1
        bounce = 12'b1110_1110_0000;
        seen_any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            raw_in = {bounce[i], 1'b0};
            tick();
            if (level_out[1] || pulse_out[1]) seen_any = 1'b1;
        end
        repeat (6) begin
            tick();
            if (level_out[1] || pulse_out[1]) seen_any = 1'b1;
        end
        chk("bounce_quiet", {1'b0, seen_any}, 2'b00);

        // 5: reset while channel 0 is in RISE_WAIT
        raw_in = 2'b01;
        repeat (4) tick();
        #3;
        n_reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_level", level_out, 2'b00);
        chk("midrst_pulse", pulse_out, 2'b00);
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b1;
        first = -1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (pulse_out[0] && first < 0) first = e;
        end
        chk("midrst_pulse_edge", 4'(first), 4'd6);
        raw_in = 2'b00;
        repeat (12) tick();

        // 6: long hold; repeat strobes only with AUTO_REPEAT_EN
        raw_in = 2'b01;
        for (int e = 0; e < 34; e++) begin
            tick();
            want = 2'b00;
            if (e == 6) want = 2'b01;
`ifdef AUTO_REPEAT_EN
            if (e == 14 || e == 22 || e == 30) want = 2'b01;
`endif
            chk("hold_pulse", pulse_out, want);
        end
        raw_in = 2'b00;
        repeat (12) tick();

        // Random toggling with random hold lengths per channel
        for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 8);
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < CH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    raw_in[c] = ~raw_in[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 24))
                                                          : int'($urandom_range(1, 7));
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
